axi_stream_strip_header: RTL and testbench
==========================================

// Module: axi_stream_strip_header
// PURPOSE
// - Downstream companion of the header-insert stage: removes a per-packet byte count from the front of each AXI-Stream packet.
// - Re-packs the remaining payload into full, MSB-first beats.
// - Sits between the insert/transport path and the payload consumer.
// - Byte 0 of a beat is data[DATA_WD-1 -: 8] and maps to keep[DATA_BYTE_WD-1].
// - Non-last beats are full; last beats are left-aligned contiguous.
// PARAMETERS
// - DATA_WD       32             stream data width, multiple of 8
// - DATA_BYTE_WD  DATA_WD/8      bytes per beat (W)
// - CNT_WD        $clog2(W)+1    width of strip_bytes
// PORTS
// - clk           in   1             clock, all logic on posedge
// - rst_n         in   1             reset, synchronous, active-low
// - strip_valid   in   1             strip count for the next packet is valid
// - strip_bytes   in   CNT_WD        header bytes to remove (S); values > W are clamped to W
// - strip_ready   out  1             count accepted (IDLE only)
// - valid_in      in   1             input beat valid
// - data_in       in   DATA_WD       input data
// - keep_in       in   W             input byte enables
// - last_in       in   1             last beat of input packet
// - ready_in      out  1             input beat accepted
// - valid_out     out  1             output beat valid (registered)
// - data_out      out  DATA_WD       output data (registered)
// - keep_out      out  W             output byte enables (registered)
// - last_out      out  1             output last (registered)
// - ready_out     in   1             downstream ready
// - runt_pulse    out  1             1-cycle pulse: packet was ≤ S bytes and was dropped
// BEHAVIOUR
// - Reset: state=IDLE; valid_out, last_out, runt_pulse = 0; data_out, keep_out, residual = 0; strip_ready=1 after reset.
// - States:
//   - IDLE: strip_ready=1. On strip handshake, latch S, set R=W-S, go to FIRST.
//   - FIRST: accept beat 0. Bytes [0,S) are header; bytes [S,n) go to the residual.
//     - Non-last: go to STREAM. Nothing is emitted this beat.
//     - Last with n≤S: pulse runt_pulse, emit nothing, go to IDLE.
//     - Last with n>S: emit n-S bytes with last_out=1, go to IDLE.
//   - STREAM: each accepted beat (n bytes) emits residual(R) ++ incoming[0,W-R). Residual then becomes incoming[W-R,n).
//     - Last with R+n≤W: emit R+n bytes with last_out=1, go to IDLE.
//     - Last with R+n>W: emit a full beat, go to FLUSH.
//   - FLUSH: ready_in=0. Emit residual (R+n-W bytes) with last_out=1, go to IDLE.
// - S=0 gives R=W: pass-through delayed by one input beat. S=W gives R=0: beat 0 is dropped entirely.
// - ready_in = (state==FIRST|STREAM) & (~valid_out | ready_out). ready_in never depends combinationally on valid_in.
// - Output register loads only when (~valid_out | ready_out). While valid_out=1 & ready_out=0, data/keep/last hold stable.
// - Latency: one clk from the causing input handshake, or FLUSH entry, to valid_out.
// - Throughput: 1 beat/clk in STREAM under full ready. FLUSH adds exactly 1 bubble beat.
// - keep_out is always left-aligned contiguous and all-ones on non-last beats. Output keep is derived from byte counts; keep_in on non-last beats is not checked.
// - A zero-byte output beat is never generated.
// - strip_valid is ignored outside IDLE. A new packet cannot start until its count is accepted.
// - Reset mid-packet aborts the packet. No partial last is emitted. Next packet requires a fresh strip handshake.
// CONFIGURATION
// - HEADER_CAPTURE_EN defined:
//   - Adds ports hdr_valid (out, 1), hdr_data (out, DATA_WD), hdr_keep (out, W).
//   - In the cycle after the FIRST-state handshake, hdr_valid pulses for 1 clk.
//   - hdr_data holds the S removed bytes left-aligned; hdr_keep marks those S bytes.
//   - Pulses even for runt packets. hdr_valid=0 when S=0. All of these ports reset to 0.
// - HEADER_CAPTURE_EN undefined: ports and capture logic are absent; behaviour is otherwise identical.
// TESTING (DATA_WD=32)
// - S=0; beats 00112233, 44556677, 8899xxxx (keep 1100, last) -> identical 3 beats; last keep 1100.
// - S=1; AABBCCDD, EEFF0011, 2233xxxx (keep 1100, last) -> BBCCDDEE, FF001122, 33xxxxxx (keep 1000, last).
// - S=3; 00112233, 44556677 (last, full) -> 33445566 (keep 1111), then FLUSH 77xxxxxx (keep 1000, last); ready_in=0 during FLUSH.
// - S=4; single beat DEADBEEF (keep 1111, last) -> runt_pulse=1 for one clk; no valid_out; strip_ready=1 next clk.
// - S=2, 20-beat packet, ready_out random 50% -> byte stream equals input minus first 2 bytes; no data change while stalled.
// - rst_n=0 for 1 clk mid-packet -> valid_out=0 next clk; state IDLE; next packet with S=1 is stripped correctly.

Source files
------------

// File: rtl/axi_stream_strip_header.sv
// Strips a per-packet header byte count from AXI-Stream packets and re-packs the payload MSB-first.
// Optional header capture outputs are built when HEADER_CAPTURE_EN is defined.
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    strip_valid,
  input  logic [CNT_WD-1:0]       strip_bytes,
  output logic                    strip_ready,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    runt_pulse
`ifdef HEADER_CAPTURE_EN
  ,
  output logic                    hdr_valid,
  output logic [DATA_WD-1:0]      hdr_data,
  output logic [DATA_BYTE_WD-1:0] hdr_keep
`endif
);

  // state  | meaning
  // IDLE   | waiting for the strip count of the next packet
  // FIRST  | waiting for beat 0, which carries the header
  // STREAM | re-packing residual bytes with each incoming beat
  // FLUSH  | emitting the leftover residual after an overflowing last beat
  typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

  localparam logic [CNT_WD-1:0] W_CNT = CNT_WD'(DATA_BYTE_WD);
  localparam logic [CNT_WD:0]   W_SUM = (CNT_WD + 1)'(DATA_BYTE_WD);

  function automatic logic [CNT_WD+2:0] sh(input logic [CNT_WD-1:0] c);
    return {c, 3'b000};
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [CNT_WD-1:0] c);
    return ~({DATA_BYTE_WD{1'b1}} >> c);
  endfunction

  function automatic logic [DATA_WD-1:0] mask_of(input logic [CNT_WD-1:0] c);
    return ~({DATA_WD{1'b1}} >> sh(c));
  endfunction

  function automatic logic [CNT_WD-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] k);
    logic [CNT_WD-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CNT_WD'(k[i]);
    return c;
  endfunction

  state_t               state, state_nxt;
  logic [CNT_WD-1:0]    s_q, s_nxt;
  logic [CNT_WD-1:0]    r_q, r_nxt;
  logic [DATA_WD-1:0]   res_q, res_nxt;
  logic                 out_en, in_hs;
  logic [CNT_WD-1:0]    s_clamp, n_in, take;
  logic [CNT_WD:0]      sum;
  logic                 emit, emit_last, runt_nxt;
  logic [DATA_WD-1:0]   emit_data;
  logic [CNT_WD-1:0]    emit_cnt;

  assign out_en  = ~valid_out | ready_out;
  assign in_hs   = valid_in & ready_in;
  assign s_clamp = (strip_bytes > W_CNT) ? W_CNT : strip_bytes;
  // Non-last beats are treated as full regardless of keep_in.
  assign n_in    = last_in ? popcnt(keep_in) : W_CNT;
  assign take    = W_CNT - r_q;
  assign sum     = {1'b0, r_q} + {1'b0, n_in};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      s_q   <= '0;
      r_q   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      s_q   <= s_nxt;
      r_q   <= r_nxt;
      res_q <= res_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    s_nxt       = s_q;
    r_nxt       = r_q;
    res_nxt     = res_q;
    emit        = 1'b0;
    emit_data   = '0;
    emit_cnt    = '0;
    emit_last   = 1'b0;
    runt_nxt    = 1'b0;
    strip_ready = (state == IDLE);
    ready_in    = ((state == FIRST) || (state == STREAM)) && out_en;
    case (state)
      IDLE: begin
        if (strip_valid) begin
          s_nxt     = s_clamp;
          r_nxt     = W_CNT - s_clamp;
          state_nxt = FIRST;
        end
      end
      FIRST: begin
        if (in_hs) begin
          res_nxt = data_in << sh(s_q);
          if (!last_in) begin
            state_nxt = STREAM;
          end else begin
            state_nxt = IDLE;
            if (n_in > s_q) begin
              emit      = 1'b1;
              emit_data = data_in << sh(s_q);
              emit_cnt  = n_in - s_q;
              emit_last = 1'b1;
            end else begin
              runt_nxt = 1'b1;
            end
          end
        end
      end
      STREAM: begin
        if (in_hs) begin
          emit_data = res_q | (data_in >> sh(r_q));
          res_nxt   = data_in << sh(take);
          if (!last_in) begin
            emit     = 1'b1;
            emit_cnt = W_CNT;
          end else if (sum <= W_SUM) begin
            state_nxt = IDLE;
            emit      = (sum != '0);
            emit_cnt  = CNT_WD'(sum);
            emit_last = 1'b1;
          end else begin
            emit      = 1'b1;
            emit_cnt  = W_CNT;
            r_nxt     = CNT_WD'(sum - W_SUM);
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_en) begin
          emit      = 1'b1;
          emit_data = res_q;
          emit_cnt  = r_q;
          emit_last = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bytes beyond the emitted count are zeroed so stale residual never leaks out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      keep_out   <= '0;
      last_out   <= 1'b0;
      runt_pulse <= 1'b0;
    end else begin
      runt_pulse <= runt_nxt;
      if (out_en) begin
        valid_out <= emit;
        if (emit) begin
          data_out <= emit_data & mask_of(emit_cnt);
          keep_out <= keep_of(emit_cnt);
          last_out <= emit_last;
        end
      end
    end
  end

`ifdef HEADER_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_valid <= 1'b0;
      hdr_data  <= '0;
      hdr_keep  <= '0;
    end else begin
      hdr_valid <= (state == FIRST) && in_hs && (s_q != '0);
      if ((state == FIRST) && in_hs) begin
        hdr_data <= data_in & mask_of(s_q);
        hdr_keep <= keep_of(s_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header with DATA_WD=32.
module tb_axi_stream_strip_header;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strip_valid;
  logic [2:0]  strip_bytes;
  logic        strip_ready;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        runt_pulse;

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .strip_valid(strip_valid), .strip_bytes(strip_bytes), .strip_ready(strip_ready),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out), .runt_pulse(runt_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t out_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  stall_pending = 1'b0;
  beat_t stall_beat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] kmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  // Output collector and stall-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        chk("stall_valid", valid_out, 1'b1);
        chk("stall_hold", {data_out, keep_out, last_out}, stall_beat);
      end
      stall_pending = valid_out && !ready_out;
      stall_beat    = '{d: data_out, k: keep_out, l: last_out};
      if (valid_out && ready_out) out_q.push_back('{d: data_out, k: keep_out, l: last_out});
    end
  end

  task automatic send_strip(input logic [2:0] s);
    logic ok;
    int   t;
    strip_valid = 1'b1;
    strip_bytes = s;
    t = 0;
    do begin
      @(negedge clk); ok = strip_ready;
      @(posedge clk); #1; t++;
    end while (!ok && t < 1000);
    strip_valid = 1'b0;
    if (!ok) chk("strip_timeout", ok, 1'b1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic ok;
    int   t;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    t = 0;
    do begin
      @(negedge clk); ok = ready_in;
      @(posedge clk); #1; t++;
    end while (!ok && t < 1000);
    valid_in = 1'b0;
    if (!ok) chk("beat_timeout", ok, 1'b1);
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                             input logic l);
    beat_t b;
    int    t;
    t = 0;
    while (out_q.size() == 0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk({tag, "_avail"}, (out_q.size() != 0), 1'b1);
    if (out_q.size() != 0) begin
      b = out_q.pop_front();
      chk({tag, "_data"}, b.d & kmask(k), d & kmask(k));
      chk({tag, "_keep"}, b.k, k);
      chk({tag, "_last"}, b.l, l);
    end
  endtask

  initial begin
    logic [7:0] exp_bytes[$];
    logic [31:0] ed, bd;
    logic [3:0]  ek;
    int          cnt;
    logic        done;

    rst_n = 1'b0; strip_valid = 1'b0; strip_bytes = '0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0; ready_out = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_last_out", last_out, 1'b0);
    chk("rst_runt", runt_pulse, 1'b0);
    chk("rst_data_keep", {data_out, keep_out}, 36'h0);
    chk("rst_strip_ready", strip_ready, 1'b1);
    chk("rst_ready_in", ready_in, 1'b0);
    @(posedge clk); #1;

    // S=0: pass-through delayed by one beat
    send_strip(3'd0);
    send_beat(32'h00112233, 4'b1111, 1'b0);
    send_beat(32'h44556677, 4'b1111, 1'b0);
    send_beat(32'h88990000, 4'b1100, 1'b1);
    expect_beat("s0_b0", 32'h00112233, 4'b1111, 1'b0);
    expect_beat("s0_b1", 32'h44556677, 4'b1111, 1'b0);
    expect_beat("s0_b2", 32'h88990000, 4'b1100, 1'b1);

    // S=1
    send_strip(3'd1);
    send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    send_beat(32'hEEFF0011, 4'b1111, 1'b0);
    send_beat(32'h22330000, 4'b1100, 1'b1);
    expect_beat("s1_b0", 32'hBBCCDDEE, 4'b1111, 1'b0);
    expect_beat("s1_b1", 32'hFF001122, 4'b1111, 1'b0);
    expect_beat("s1_b2", 32'h33000000, 4'b1000, 1'b1);

    // S=3 with FLUSH
    send_strip(3'd3);
    send_beat(32'h00112233, 4'b1111, 1'b0);
    send_beat(32'h44556677, 4'b1111, 1'b1);
    @(negedge clk);
    chk("s3_flush_ready_in", ready_in, 1'b0);
    chk("s3_latency_valid", valid_out, 1'b1);
    @(posedge clk); #1;
    expect_beat("s3_b0", 32'h33445566, 4'b1111, 1'b0);
    expect_beat("s3_b1", 32'h77000000, 4'b1000, 1'b1);

    // S=4 runt packet
    send_strip(3'd4);
    send_beat(32'hDEADBEEF, 4'b1111, 1'b1);
    @(negedge clk);
    chk("runt_pulse_hi", runt_pulse, 1'b1);
    chk("runt_no_valid", valid_out, 1'b0);
    chk("runt_strip_ready", strip_ready, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("runt_pulse_lo", runt_pulse, 1'b0);
    chk("runt_no_output", out_q.size(), 0);
    @(posedge clk); #1;

    // Count above W clamps to W: beat 0 dropped entirely
    send_strip(3'd7);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b1);
    expect_beat("clamp_b0", 32'h55667788, 4'b1111, 1'b1);

    // S=2, 20 beats, random backpressure
    exp_bytes.delete();
    for (int b = 0; b < 20; b++)
      for (int j = 0; j < 4; j++)
        if ((b*4 + j) >= 2 && (b < 19 || j < 3)) exp_bytes.push_back(8'(b*4 + j + 16));
    send_strip(3'd2);
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 20; b++) begin
          for (int j = 0; j < 4; j++) bd[31-8*j -: 8] = 8'(b*4 + j + 16);
          send_beat(bd, (b == 19) ? 4'b1110 : 4'b1111, (b == 19));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ready_out = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        ready_out = 1'b1;
      end
    join
    for (int n = 0; n < 30 && exp_bytes.size() > 0; n++) begin
      cnt = (exp_bytes.size() < 4) ? exp_bytes.size() : 4;
      ed = '0;
      for (int j = 0; j < cnt; j++) ed[31-8*j -: 8] = exp_bytes.pop_front();
      ek = 4'(~(4'b1111 >> cnt));
      expect_beat("rnd", ed, ek, (exp_bytes.size() == 0));
    end
    repeat (3) @(posedge clk); #1;
    chk("rnd_no_extra", out_q.size(), 0);

    // Reset mid-packet with an output beat stalled
    ready_out = 1'b0;
    send_strip(3'd1);
    send_beat(32'hA0A1A2A3, 4'b1111, 1'b0);
    send_beat(32'hB0B1B2B3, 4'b1111, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", valid_out, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_out = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid_out", valid_out, 1'b0);
    chk("mid_rst_strip_ready", strip_ready, 1'b1);
    chk("mid_rst_ready_in", ready_in, 1'b0);
    @(posedge clk); #1;
    out_q.delete();
    send_strip(3'd1);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b1);
    expect_beat("post_rst_b0", 32'h02030405, 4'b1111, 1'b0);
    expect_beat("post_rst_b1", 32'h06070800, 4'b1110, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
